// File: rtl/sample_transfer_scheduler.sv
// Capture/transfer sequencer between the ADC reader and the serial writer:
// buffers one burst of DEPTH samples, then drains them in arrival order via a start/busy handshake.
module sample_transfer_scheduler #(
  parameter int unsigned SAMPLE_W = 12,
  parameter int unsigned DEPTH    = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm,
  input  logic                abort,
  input  logic                adc_valid,
  input  logic [SAMPLE_W-1:0] adc_data,
  input  logic                tx_busy,
  output logic                tx_start,
  output logic [SAMPLE_W-1:0] tx_data,
  output logic                adc_en,
  output logic                transmitting,
  output logic                done,
  output logic                dropped,
  output logic [CNT_W-1:0]    sample_count
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    DRAIN   = 3'd2,
    TX_ACK  = 3'd3,
    TX_WAIT = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t              state;
  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    rd_ptr;
  logic                busy_q;

  // Sequencer, sample buffer and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      busy_q       <= 1'b0;
      tx_start     <= 1'b0;
      tx_data      <= '0;
      adc_en       <= 1'b0;
      transmitting <= 1'b0;
      done         <= 1'b0;
      dropped      <= 1'b0;
      sample_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      tx_start <= 1'b0;
      busy_q   <= tx_busy;
      if (abort) begin
        state        <= IDLE;
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        adc_en       <= 1'b0;
        transmitting <= 1'b0;
        done         <= 1'b0;
        dropped      <= 1'b0;
        sample_count <= '0;
      end else begin
        // Samples arriving outside a capture window are lost; flag it.
        if (adc_valid && (state != IDLE) && (state != COLLECT)) begin
          dropped <= 1'b1;
        end
        unique case (state)
          IDLE, DONE: begin
            if (arm) begin
              state        <= COLLECT;
              wr_ptr       <= '0;
              rd_ptr       <= '0;
              sample_count <= '0;
              dropped      <= 1'b0;
              adc_en       <= 1'b1;
              done         <= 1'b0;
            end
          end
          COLLECT: begin
            if (adc_valid) begin
              mem[wr_ptr] <= adc_data;
              wr_ptr      <= wr_ptr + ONE;
              if (wr_ptr == LAST_IDX) begin
                state        <= DRAIN;
                sample_count <= '0;
                adc_en       <= 1'b0;
                transmitting <= 1'b1;
              end else begin
                sample_count <= sample_count + ONE;
              end
            end
          end
          DRAIN: begin
            // Writer must be seen idle two cycles running before a new frame is launched.
            if (!tx_busy && !busy_q) begin
              tx_data  <= mem[rd_ptr];
              tx_start <= 1'b1;
              state    <= TX_ACK;
            end
          end
          TX_ACK: begin
            if (tx_busy) begin
              state <= TX_WAIT;
            end
          end
          TX_WAIT: begin
            if (!tx_busy) begin
              rd_ptr       <= rd_ptr + ONE;
              sample_count <= sample_count + ONE;
              if (sample_count == LAST_IDX) begin
                state        <= DONE;
                transmitting <= 1'b0;
                done         <= 1'b1;
              end else begin
                state <= DRAIN;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sample_transfer_scheduler.sv
// Scoreboard bench for sample_transfer_scheduler: stimulus pushes expected samples,
// a monitor pops them on every tx_start; a writer model answers with busy pulses.
module tb_sample_transfer_scheduler;

  localparam int unsigned SAMPLE_W = 12;
  localparam int unsigned DEPTH    = 10;
  localparam int unsigned CNT_W    = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                arm = 1'b0;
  logic                abort = 1'b0;
  logic                adc_valid = 1'b0;
  logic [SAMPLE_W-1:0] adc_data = '0;
  logic                wr_busy = 1'b0;
  logic                hold_busy = 1'b0;
  logic                tx_busy;
  logic                tx_start;
  logic [SAMPLE_W-1:0] tx_data;
  logic                adc_en;
  logic                transmitting;
  logic                done;
  logic                dropped;
  logic [CNT_W-1:0]    sample_count;

  assign tx_busy = wr_busy | hold_busy;

  sample_transfer_scheduler #(
    .SAMPLE_W(SAMPLE_W),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .arm         (arm),
    .abort       (abort),
    .adc_valid   (adc_valid),
    .adc_data    (adc_data),
    .tx_busy     (tx_busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .adc_en      (adc_en),
    .transmitting(transmitting),
    .done        (done),
    .dropped     (dropped),
    .sample_count(sample_count)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int starts = 0;
  int last_start_cyc = 0;
  int stim_evt = 0;
  int fall_evt = 0;
  int busy_len = 36;
  int wr_cnt = 0;

  // Reference model: phase 0 idle, 1 collecting, 2 transferring, 3 done.
  int                  phase = 0;
  int                  stored = 0;
  logic                exp_dropped = 1'b0;
  logic [SAMPLE_W-1:0] exp_q[$];
  logic [SAMPLE_W-1:0] mon_exp;

  initial forever #10 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Writer model: busy for busy_len cycles after each tx_start.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      wr_busy = 1'b0;
      wr_cnt  = 0;
    end else if (tx_start) begin
      wr_busy = 1'b1;
      wr_cnt  = busy_len;
    end else if (wr_cnt > 0) begin
      wr_cnt--;
      if (wr_cnt == 0) begin
        wr_busy  = 1'b0;
        fall_evt = cyc;
      end
    end
  end

  // Monitor: every tx_start must carry the oldest pending sample, 2 cycles after its trigger.
  initial forever begin
    @(negedge clk);
    if (rst && tx_start) begin
      starts++;
      last_start_cyc = cyc;
      check("transmitting_at_start", 32'(transmitting), 32'd1);
      check("start_latency", 32'(cyc - ((stim_evt > fall_evt) ? stim_evt : fall_evt)), 32'd2);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_tx_start: tx_data=0x%0h with no sample pending (cycle %0d)", tx_data, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        check("tx_data_order", 32'(tx_data), 32'(mon_exp));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_sample(input logic [SAMPLE_W-1:0] d);
    adc_valid = 1'b1;
    adc_data  = d;
    if (phase == 1) begin
      exp_q.push_back(d);
      stored++;
      if (stored == DEPTH) begin
        phase    = 2;
        stim_evt = cyc;
      end
    end else if (phase >= 2) begin
      exp_dropped = 1'b1;
    end
    tick();
    adc_valid = 1'b0;
    check("dropped", 32'(dropped), 32'(exp_dropped));
    if (phase == 1) begin
      check("sample_count_collect", 32'(sample_count), 32'(stored));
      check("adc_en_collect", 32'(adc_en), 32'd1);
    end
  endtask

  task automatic do_arm(input bit with_abort);
    arm   = 1'b1;
    abort = with_abort;
    if (with_abort) begin
      phase = 0;
      stored = 0;
      exp_dropped = 1'b0;
      exp_q.delete();
    end else if (phase == 0 || phase == 3) begin
      phase = 1;
      stored = 0;
      exp_dropped = 1'b0;
    end
    tick();
    arm   = 1'b0;
    abort = 1'b0;
    check("adc_en_after_arm", 32'(adc_en), 32'(phase == 1));
    check("dropped_after_arm", 32'(dropped), 32'(exp_dropped));
  endtask

  task automatic do_abort();
    abort = 1'b1;
    phase = 0;
    stored = 0;
    exp_dropped = 1'b0;
    exp_q.delete();
    tick();
    abort = 1'b0;
    check("abort_sample_count", 32'(sample_count), 32'd0);
    check("abort_adc_en", 32'(adc_en), 32'd0);
    check("abort_flags", 32'({transmitting, done, dropped, tx_start}), 32'd0);
  endtask

  task automatic run_burst(input bit seq, input int nsamp, input int gapmax, input int blen,
                           input bit hold_last, output logic [SAMPLE_W-1:0] last);
    logic [SAMPLE_W-1:0] d;
    busy_len = blen;
    last = '0;
    do_arm(1'b0);
    for (int i = 0; i < nsamp; i++) begin
      d = seq ? SAMPLE_W'(i + 1) : SAMPLE_W'($urandom);
      if (hold_last && i == nsamp - 1) hold_busy = 1'b1;
      send_sample(d);
      last = d;
      repeat ($urandom_range(gapmax, 0)) tick();
    end
  endtask

  task automatic wait_starts(input int target, input int budget);
    int n = 0;
    while (starts < target && n < budget) begin
      tick();
      n++;
    end
    if (starts < target) begin
      total++;
      bad++;
      $display("FAIL start_timeout: starts=%0d want %0d after %0d cycles", starts, target, budget);
    end
  endtask

  task automatic wait_done(input int budget, input logic [SAMPLE_W-1:0] last);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: done=%0d after %0d cycles want 1", done, budget);
    end else begin
      phase = 3;
      check("done_latency", 32'(cyc - fall_evt), 32'd1);
      check("queue_empty_at_done", 32'(exp_q.size()), 32'd0);
      check("sample_count_done", 32'(sample_count), 32'(DEPTH));
      check("tx_data_hold", 32'(tx_data), 32'(last));
      check("done_outputs", 32'({transmitting, adc_en, tx_start}), 32'd0);
    end
  endtask

  initial begin
    logic [SAMPLE_W-1:0] last;
    logic [SAMPLE_W-1:0] d;
    int s0;
    int rel;

    // Reset values
    repeat (3) tick();
    check("reset_outputs", 32'({tx_start, adc_en, transmitting, done, dropped}), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'd0);
    check("reset_sample_count", 32'(sample_count), 32'd0);
    rst = 1'b1;
    tick();

    // T6a: arm+abort together in IDLE stays idle; adc_valid in IDLE is ignored silently
    do_arm(1'b1);
    send_sample(12'h123);
    repeat (3) tick();
    check("t6_idle_adc_en", 32'(adc_en), 32'd0);
    check("t6_idle_done", 32'(done), 32'd0);

    // T1: sequential data, 36-cycle writer
    run_burst(1'b1, DEPTH, 0, 36, 1'b0, last);
    wait_done(DEPTH * 44 + 50, last);

    // T2: abort mid-collect, nothing may be transmitted
    s0 = starts;
    run_burst(1'b0, 4, 1, 5, 1'b0, last);
    do_abort();
    repeat (40) tick();
    check("t2_no_tx_start", 32'(starts - s0), 32'd0);
    check("t2_adc_en", 32'(adc_en), 32'd0);

    // T6b: arm during COLLECT has no effect
    run_burst(1'b0, 3, 0, 3, 1'b0, last);
    do_arm(1'b0);
    check("t6_arm_in_collect_count", 32'(sample_count), 32'd3);
    for (int i = 0; i < int'(DEPTH) - 3; i++) begin
      d = SAMPLE_W'($urandom);
      send_sample(d);
      last = d;
    end
    wait_done(DEPTH * 12 + 50, last);

    // T3: sample during TX_WAIT is dropped and flagged; next arm clears the flag
    s0 = starts;
    run_burst(1'b0, DEPTH, 2, 10, 1'b0, last);
    wait_starts(s0 + 1, 40);
    repeat (5) tick();
    send_sample(12'hFFF);
    wait_done(DEPTH * 20 + 50, last);
    check("t3_dropped_sticky", 32'(dropped), 32'd1);

    // Randomized bursts
    for (int b = 0; b < 4; b++) begin
      run_burst(1'b0, DEPTH, 3, int'($urandom_range(8, 1)), 1'b0, last);
      wait_done(DEPTH * 20 + 50, last);
    end

    // T4: writer busy when DRAIN is entered
    s0 = starts;
    run_burst(1'b0, DEPTH, 1, 4, 1'b1, last);
    repeat (20) tick();
    check("t4_no_start_while_busy", 32'(starts - s0), 32'd0);
    hold_busy = 1'b0;
    rel = cyc;
    stim_evt = cyc;
    wait_starts(s0 + 1, 8);
    check("t4_start_after_release", 32'(last_start_cyc - rel), 32'd2);
    wait_done(DEPTH * 14 + 50, last);

    // T5: reset during TX_WAIT of sample 5, then a clean T1 burst
    s0 = starts;
    run_burst(1'b0, DEPTH, 0, 20, 1'b0, last);
    wait_starts(s0 + 5, 200);
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("t5_async_reset_flags", 32'({tx_start, adc_en, transmitting, done, dropped}), 32'd0);
    check("t5_async_reset_data", 32'(tx_data), 32'd0);
    check("t5_async_reset_count", 32'(sample_count), 32'd0);
    phase = 0;
    stored = 0;
    exp_dropped = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b1;
    tick();
    run_burst(1'b1, DEPTH, 0, 36, 1'b0, last);
    wait_done(DEPTH * 44 + 50, last);

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
